// File: rtl/loadable_down_counter_pkg.sv
// Shared definitions for the loadable down counter: state encoding and default width.
package loadable_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/loadable_down_counter_if.sv
// Load handshake, run controls and status outputs of the loadable down counter.
interface loadable_down_counter_if
    import loadable_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             auto_reload;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output load_value,
        output enable,
        output auto_reload,
        output stop,
        input  load_ready,
        input  count,
        input  tc,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  enable,
        input  auto_reload,
        input  stop,
        output load_ready,
        output count,
        output tc,
        output busy,
        output done
    );

endinterface

// File: rtl/loadable_down_counter.sv
// Programmable down-counting timer with valid/ready load, one-cycle terminal-count
// pulse and optional auto-reload.
module loadable_down_counter
    import loadable_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic                    clock,
    input  logic                    Reset,
    loadable_down_counter_if.slave  bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    // tc defaults low every cycle so it can only ever be a single-cycle pulse
    // unless a fresh terminal event re-arms it.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.load_valid) begin
                        r_count  <= bus.load_value;
                        r_reload <= bus.load_value;
                        if (bus.load_value != '0) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= DONE;
                            r_tc    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Decrement stops at 1 so the counter can never underflow.
                    if (bus.stop) begin
                        r_state <= IDLE;
                    end else if (bus.enable) begin
                        if (r_count > WIDTH'(1)) begin
                            r_count <= r_count - WIDTH'(1);
                        end else if (bus.auto_reload) begin
                            r_count <= r_reload;
                            r_tc    <= 1'b1;
                        end else begin
                            r_count <= '0;
                            r_tc    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.count      = r_count;
    assign bus.tc         = r_tc;
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
    assign bus.load_ready = (r_state == IDLE) || (r_state == DONE);

endmodule

// File: tb/tb_loadable_down_counter.sv
// Directed, table-driven self-checking bench for loadable_down_counter.
module tb_loadable_down_counter;

    logic clock;
    logic Reset;
    int   checkCount;
    int   passCount;

    loadable_down_counter_if #(.WIDTH(4)) bus ();

    loadable_down_counter #(.WIDTH(4)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       lv;
        logic [3:0] val;
        logic       en;
        logic       ar;
        logic       st;
        logic [3:0] expCount;
        logic       expTc;
        logic       expBusy;
        logic       expDone;
        logic       expReady;
    } vec_t;

    vec_t vecs[16];

    task automatic applyStimulus(input logic lv, input logic [3:0] val, input logic en,
                                 input logic ar, input logic st);
        bus.load_valid  = lv;
        bus.load_value  = val;
        bus.enable      = en;
        bus.auto_reload = ar;
        bus.stop        = st;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expCount, input logic expTc,
                               input logic expBusy, input logic expDone, input logic expReady);
        logic [7:0] act;
        logic [7:0] exp;
        act = {bus.count, bus.tc, bus.busy, bus.done, bus.load_ready};
        exp = {expCount, expTc, expBusy, expDone, expReady};
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got count=%0d tc=%b busy=%b done=%b ready=%b, want count=%0d tc=%b busy=%b done=%b ready=%b",
                     name, bus.count, bus.tc, bus.busy, bus.done, bus.load_ready,
                     expCount, expTc, expBusy, expDone, expReady);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tcSeen;
        logic [3:0] arSeq[9];
        checkCount = 0;
        passCount  = 0;

        // One-shot of 5, DONE behaviour, then enable gating and stop from RUN, then IDLE.
        vecs[0]  = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};

        arSeq = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};

        Reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        Reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].ar, vecs[i].st);
            tick();
            checkOutput($sformatf("table_%0d", i), vecs[i].expCount, vecs[i].expTc,
                        vecs[i].expBusy, vecs[i].expDone, vecs[i].expReady);
        end

        // Auto-reload with period 3: count never shows 0, tc on each reload.
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("ar_load", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput($sformatf("ar_step_%0d", i), arSeq[i], (i % 3) == 2, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("ar_stop", 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero load goes straight to DONE with a single tc pulse.
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("zero_load", 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("zero_load_after", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // A load offered during RUN must be ignored.
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("run_load4", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("run_ignore9_a", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("run_ignore9_b", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("run_stop", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Maximum load: 15 decrements, exactly one tc, no wrap afterwards.
        applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("max_load", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tcSeen = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus.tc === 1'b1) tcSeen++;
            checkOutput($sformatf("max_step_%0d", k), 4'(15 - k), k == 15, k != 15, k == 15, k == 15);
        end
        tick();
        if (bus.tc === 1'b1) tcSeen++;
        checkOutput("max_no_wrap", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCount++;
        if (tcSeen == 1) passCount++;
        else $display("[TB] FAIL max_tc_count: got %0d tc pulses, want 1", tcSeen);

        // Asynchronous reset mid-run, observed between clock edges.
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("pre_reset_run", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        Reset = 1'b1;
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("post_reset_load", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/loadable_down_counter.md
Name: loadable_down_counter

Overview:
- Programmable down-counting timer; the counting-down counterpart to the team's free-running binary up counter.
- Accepts a start value over a valid/ready load handshake, then decrements on each enabled clock.
- Emits a one-cycle terminal-count pulse on reaching zero, with an optional auto-reload mode.
- Used as the interval/timeout source next to the up counters in the Flip-Flop & Counter designs.

Parameters:
- WIDTH, 4, bit width of load_value, count and the internal reload register.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset; Reset=0 forces the reset state immediately, independent of clock.
- load_valid  input  1  start-value offer.
- load_ready  output  1  block can accept a load this cycle.
- load_value  input  WIDTH  unsigned start value, sampled on a load handshake.
- enable  input  1  count-enable; when low, count holds.
- auto_reload  input  1  sampled at terminal count; 1 = reload and keep running.
- stop  input  1  abort the current run.
- count  output  WIDTH  current counter value (registered).
- tc  output  1  terminal-count pulse, exactly one cycle wide.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE, count=0, reload register=0, tc=0.
  - busy=0, done=0, load_ready=1.
- States:
  - IDLE (00), RUN (01), DONE (10).
  - 11 is unreachable; if entered, go to IDLE next cycle.
- load_ready = 1 in IDLE and DONE, 0 in RUN. It is a combinational decode of state only.
- Load handshake (load_valid=1 and load_ready=1 at posedge):
  - count<=load_value and reload<=load_value.
  - If load_value≠0, next state=RUN.
  - If load_value=0, next state=DONE and tc=1 for the following cycle.
- RUN, per posedge, highest priority first:
  - stop=1: state<=IDLE; count holds its value; tc stays 0.
  - enable=0: hold everything.
  - enable=1 and count>1: count<=count-1.
  - enable=1, count=1, auto_reload=1: count<=reload, tc<=1, stay in RUN.
  - enable=1, count=1, auto_reload=0: count<=0, tc<=1, state<=DONE.
- Timing: a load of N with enable held high gives tc high in the cycle where count first reads 0, N cycles after the handshake edge.
- Auto-reload period is N cycles; count never shows 0 in that mode.
- tc is registered and deasserts the cycle after it asserts, unless a new terminal event occurs.
- DONE: count=0 and done=1. A load restarts the counter; stop is ignored.
- IDLE: count holds its last value; stop and enable are ignored.
- load_valid in RUN is ignored because load_ready=0. The offering side must hold it.
- Arithmetic: unsigned, WIDTH bits. No underflow is possible because decrement never occurs at count=0.
- Maximum load is 2^WIDTH-1, i.e. 15 cycles at the default width.
- Reset asserted mid-run aborts immediately to the reset state. The first edge after release behaves as from IDLE.

Decomposition:
- Shared counter package holds:
  - state encoding constants IDLE/RUN/DONE (2-bit);
  - default WIDTH=4.
- Single module. No sub-module is needed: the datapath (count, reload register) and the 3-state FSM are both small.

Test Plan:
- Reset check: Reset=0 mid-run with count=7 → count=0, state IDLE, load_ready=1, tc=0, without waiting for a clock edge.
- One-shot count: load 5, enable=1, auto_reload=0 → count 5,4,3,2,1,0; tc=1 only in the count=0 cycle; done=1 afterwards; load_ready=1.
- Auto-reload: load 3, auto_reload=1, enable=1 → count 3,2,1,3,2,1,…; tc pulses every 3 cycles; done stays 0.
- Enable gating and stop: load 6, hold enable=0 for 4 cycles → count stays 6; then pulse stop → IDLE with count=6, busy=0.
- Zero load and handshake: load 0 → DONE with a single-cycle tc. load_valid=1 with value 9 during a RUN → not accepted; count is unaffected.
- Boundary: load 15 (max) → 15 decrements, tc exactly once, no wrap to 15.
